// File: rtl/sort_engine_pkg.sv
// Shared types for the sort engine.
// State encoding and bus response constants.
package sort_engine_pkg;

  typedef enum logic [3:0] {
    IDLE,
    KEY_AR,
    KEY_R,
    CMP_AR,
    CMP_R,
    DECIDE,
    SH_W,
    SH_B,
    KEY_W,
    KEY_B,
    NEXT,
    DONE,
    ERR
  } state_t;

  localparam logic [31:0] RESP_OKAY = '0;

endpackage

// File: rtl/sort_engine_cmp.sv
// Element comparator for the sort engine.
// Flags a[j] as out of order relative to the key.
module sort_cmp #(
  parameter int DATA_WDTH = 32
) (
  input  logic [DATA_WDTH-1:0] a,
  input  logic [DATA_WDTH-1:0] b,
  input  logic                 descend,
  input  logic                 signed_cmp,
  output logic                 out_of_order
);

  logic gt;
  logic lt;

  always_comb begin
    if (signed_cmp) begin
      gt = $signed(a) > $signed(b);
      lt = $signed(a) < $signed(b);
    end else begin
      gt = a > b;
      lt = a < b;
    end
    out_of_order = descend ? lt : gt;
  end

endmodule

// File: rtl/sort_engine.sv
// In-place insertion sort over a split
// read/write memory bus.
module sort_engine
  import sort_engine_pkg::*;
#(
  parameter int ADDR_WDTH = 4,
  parameter int DATA_WDTH = 32,
  parameter int RESP_WDTH = 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [ADDR_WDTH:0]   arr_size,
  input  logic [ADDR_WDTH-1:0] base_addr,
  input  logic                 descend,
  input  logic                 signed_cmp,
  output logic                 busy,
  output logic                 done,
  output logic                 error,
  output logic                 ar_valid,
  input  logic                 ar_ready,
  output logic [ADDR_WDTH-1:0] ar_address,
  input  logic                 r_valid,
  output logic                 r_ready,
  input  logic [DATA_WDTH-1:0] r_data,
  input  logic [RESP_WDTH-1:0] r_resp,
  output logic                 aw_valid,
  input  logic                 aw_ready,
  output logic [ADDR_WDTH-1:0] aw_address,
  output logic                 w_valid,
  input  logic                 w_ready,
  output logic [DATA_WDTH-1:0] w_data,
  input  logic                 b_valid,
  input  logic [RESP_WDTH-1:0] b_resp,
  output logic                 b_ready
);

  localparam int CW = ADDR_WDTH + 1;

  state_t state, state_nxt;

  logic [CW-1:0]        n_q;
  logic [CW-1:0]        i_q;
  logic signed [CW-1:0] j_q;
  logic [ADDR_WDTH-1:0] base_q;
  logic                 desc_q;
  logic                 sgn_q;
  logic                 shifted_q;
  logic [DATA_WDTH-1:0] key_q;
  logic [DATA_WDTH-1:0] cmp_q;
  logic                 ooo;
  logic                 r_err;
  logic                 b_err;
  logic                 aw_fin;
  logic                 w_fin;
  logic                 in_w;
  logic                 in_w_nxt;

  sort_cmp #(
    .DATA_WDTH(DATA_WDTH)
  ) u_cmp (
    .a           (cmp_q),
    .b           (key_q),
    .descend     (desc_q),
    .signed_cmp  (sgn_q),
    .out_of_order(ooo)
  );

  assign r_err  = r_resp != RESP_OKAY[RESP_WDTH-1:0];
  assign b_err  = b_resp != RESP_OKAY[RESP_WDTH-1:0];
  assign aw_fin = !aw_valid || aw_ready;
  assign w_fin  = !w_valid || w_ready;
  assign in_w   = state inside {SH_W, KEY_W};
  assign in_w_nxt = state_nxt inside {SH_W, KEY_W};

  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE, DONE, ERR:
        if (start) state_nxt = NEXT;
      NEXT:
        state_nxt = (i_q < n_q) ? KEY_AR : DONE;
      KEY_AR:
        if (ar_ready) state_nxt = KEY_R;
      KEY_R:
        if (r_valid) state_nxt = r_err ? ERR : CMP_AR;
      CMP_AR:
        if (ar_ready) state_nxt = CMP_R;
      CMP_R:
        if (r_valid) state_nxt = r_err ? ERR : DECIDE;
      DECIDE:
        if (j_q >= 0 && ooo) state_nxt = SH_W;
        else if (shifted_q) state_nxt = KEY_W;
        else state_nxt = NEXT;
      SH_W:
        if (aw_fin && w_fin) state_nxt = SH_B;
      SH_B:
        if (b_valid)
          state_nxt = b_err ? ERR : (j_q > 0 ? CMP_AR : KEY_W);
      KEY_W:
        if (aw_fin && w_fin) state_nxt = KEY_B;
      KEY_B:
        if (b_valid) state_nxt = b_err ? ERR : NEXT;
      default:
        state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      ar_valid  <= 1'b0;
      aw_valid  <= 1'b0;
      w_valid   <= 1'b0;
      n_q       <= '0;
      i_q       <= '0;
      j_q       <= '0;
      base_q    <= '0;
      desc_q    <= 1'b0;
      sgn_q     <= 1'b0;
      shifted_q <= 1'b0;
      key_q     <= '0;
      cmp_q     <= '0;
    end else begin
      state    <= state_nxt;
      ar_valid <= state_nxt inside {KEY_AR, CMP_AR};
      // Both write channels launch together, then retire independently.
      if (in_w_nxt && !in_w) begin
        aw_valid <= 1'b1;
        w_valid  <= 1'b1;
      end else if (in_w) begin
        aw_valid <= aw_valid && !aw_ready;
        w_valid  <= w_valid && !w_ready;
      end else begin
        aw_valid <= 1'b0;
        w_valid  <= 1'b0;
      end
      case (state)
        IDLE, DONE, ERR:
          if (start) begin
            n_q    <= arr_size;
            base_q <= base_addr;
            desc_q <= descend;
            sgn_q  <= signed_cmp;
            i_q    <= CW'(1);
          end
        KEY_R:
          if (r_valid) begin
            key_q     <= r_data;
            j_q       <= $signed(i_q - CW'(1));
            shifted_q <= 1'b0;
          end
        CMP_R:
          if (r_valid) cmp_q <= r_data;
        DECIDE:
          if (state_nxt == NEXT) i_q <= i_q + CW'(1);
        SH_B:
          if (b_valid) begin
            j_q       <= j_q - CW'(1);
            shifted_q <= 1'b1;
          end
        KEY_B:
          if (b_valid) i_q <= i_q + CW'(1);
        default: ;
      endcase
    end
  end

  assign busy    = !(state inside {IDLE, DONE, ERR});
  assign done    = state == DONE;
  assign error   = state == ERR;
  assign r_ready = state inside {KEY_R, CMP_R};
  assign b_ready = state inside {SH_B, KEY_B};

  assign ar_address = base_q + ((state == KEY_AR) ?
                      i_q[ADDR_WDTH-1:0] : j_q[ADDR_WDTH-1:0]);
  assign aw_address = base_q + j_q[ADDR_WDTH-1:0]
                      + ADDR_WDTH'(1);
  assign w_data     = (state == SH_W) ? cmp_q : key_q;

endmodule

// File: doc/sort_engine.md
SORT_ENGINE -- requirements
Module: sort_engine

Interface
REQ-001 SHALL have parameter ADDR_WDTH, default 4: memory word-address width.
REQ-002 SHALL have parameter DATA_WDTH, default 32: element width.
REQ-003 SHALL have parameter RESP_WDTH, default 1: response width; zero means OKAY.
REQ-004 SHALL have ports, in order:
- clk in 1: single clock, rising edge.
- rst_n in 1: reset, asynchronous, active-low.
- start in 1: launch request.
- arr_size in ADDR_WDTH+1: element count, 0..2^ADDR_WDTH.
- base_addr in ADDR_WDTH: address of element 0.
- descend in 1: 1 = descending order.
- signed_cmp in 1: 1 = two's-complement compare.
- busy out 1: sort in progress.
- done out 1: sort completed without error.
- error out 1: sort aborted.
- ar_valid/ar_ready/ar_address: out 1 / in 1 / out ADDR_WDTH.
- r_valid/r_ready/r_data/r_resp: in 1 / out 1 / in DATA_WDTH / in RESP_WDTH.
- aw_valid/aw_ready/aw_address: out 1 / in 1 / out ADDR_WDTH.
- w_valid/w_ready/w_data: out 1 / in 1 / out DATA_WDTH.
- b_valid/b_resp/b_ready: in 1 / in RESP_WDTH / out 1.

Function
REQ-005 SHALL perform stable in-place insertion sort: for i=1..n-1, key=a[i], shift a[j] to a[j+1] while j>=0 and out_of_order(a[j],key), then write key to a[j+1].
REQ-006 out_of_order SHALL be a[j]>key (descend=0) or a[j]<key (descend=1); equal elements never move.
REQ-007 arr_size, base_addr, descend, signed_cmp SHALL be sampled on the start cycle in IDLE/DONE/ERR and held for the whole sort.
REQ-008 Element k address SHALL be (base_addr+k) mod 2^ADDR_WDTH, so the array may wrap around the top of memory.
REQ-009 States: IDLE, KEY_AR, KEY_R, CMP_AR, CMP_R, DECIDE, SH_W, SH_B, KEY_W, KEY_B, NEXT, DONE, ERR.
REQ-010 In IDLE, DONE or ERR, start=1 SHALL clear done/error and enter NEXT with i=1; start SHALL be ignored while busy.
REQ-011 NEXT SHALL enter KEY_AR if i<n, else DONE; therefore n=0 or n=1 reaches DONE two cycles after start with no bus traffic.
REQ-012 Each *_AR state SHALL hold ar_valid=1 with a stable address until ar_ready, then enter the matching *_R state.
REQ-013 Each *_R state SHALL drive r_ready=1 and capture r_data when r_valid is high.
REQ-014 Each *_W state SHALL raise aw_valid and w_valid together; each SHALL drop independently after its own handshake, and the FSM SHALL leave the state once both handshakes have completed (same or different cycles).
REQ-015 Each *_B state SHALL drive b_ready=1 until b_valid.
REQ-016 DECIDE SHALL enter SH_W (write a[j] to j+1, then j--) if j>=0 and out_of_order; else KEY_W.
REQ-017 After SH_B, the FSM SHALL go to CMP_AR if the new j>=0, else KEY_W.
REQ-018 If no shift occurred for the current i, KEY_W/KEY_B SHALL be skipped and the FSM SHALL go straight to NEXT (new behaviour: no redundant write).
REQ-019 j SHALL be ADDR_WDTH+1 bits signed, so j=-1 is representable; i SHALL be ADDR_WDTH+1 bits unsigned.
REQ-020 Nonzero r_resp or b_resp at handshake SHALL enter ERR: error=1, busy=0, with no further bus requests.
REQ-021 DONE SHALL hold done=1 and ERR SHALL hold error=1 until the next accepted start; busy SHALL be 1 in every state except IDLE, DONE and ERR.
REQ-022 Valid signals SHALL be registered outputs; no valid SHALL depend combinationally on a ready.

Reset
REQ-023 rst_n low SHALL immediately force IDLE, mid-operation included, and drive all valids, readies, busy, done and error to 0; i, j, key and compare registers SHALL reset to 0.
REQ-024 The first start SHALL be accepted on the first rising edge with rst_n high.

Structure
REQ-025 A shared package SHALL hold the state enumeration and the RESP_OKAY constant.
REQ-026 The signed/unsigned, ascending/descending compare SHALL be one combinational sub-module, sort_cmp.

Verification
REQ-027 Scenario: base=0, n=4, mem {3,1,2,0}, ascending unsigned, zero-wait slave -> memory {0,1,2,3}, done=1, error=0.
REQ-028 Scenario: descend=1, signed_cmp=1, mem {-1,5,-8,5} -> {5,5,-1,-8}; equal 5s are never swapped (check write trace).
REQ-029 Scenario: base=14, n=4 with ADDR_WDTH=4, data at addresses 14,15,0,1 = {4,3,2,1} -> addresses read back {1,2,3,4}.
REQ-030 Scenario: presorted {1,2,3}, random ready/valid stalls -> zero write transactions, done=1.
REQ-031 Scenario: b_resp=1 on the second write -> error=1, busy=0, no further valids; a new start clears error.
REQ-032 Scenario: rst_n pulsed low during SH_W -> all outputs 0 immediately, IDLE; n=1 start -> done two cycles later with no bus activity.
